// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with an optional second (skid) entry, stall freeze and bubble injection.
// Define PIPE_SKID_REG_SKID_EN for two-entry buffering; otherwise the stage holds a single entry.
module pipe_skid_reg #(
    parameter int          DATA_W       = 136,
    parameter logic [3:0]  BUBBLE_ICODE = 4'h1,
    parameter logic [2:0]  BUBBLE_STAT  = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_icode_i,
    input  logic [2:0]        in_stat_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        out_icode_o,
    output logic [2:0]        out_stat_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         head_icode_q;
    logic [2:0]         head_stat_q;
    logic [DATA_W-1:0]  head_data_q;
    logic               push;
    logic               pop;

`ifdef PIPE_SKID_REG_SKID_EN
    logic [3:0]         skid_icode_q;
    logic [2:0]         skid_stat_q;
    logic [DATA_W-1:0]  skid_data_q;

    // Ready depends only on local state, so out_ready_i never reaches in_ready_o.
    assign in_ready_o = !stall_i && (state_q != FULL);
`else
    assign in_ready_o = !stall_i && ((state_q == EMPTY) || out_ready_i);
`endif

    assign out_valid_o = !stall_i && (state_q != EMPTY);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign out_icode_o = head_icode_q;
    assign out_stat_o  = head_stat_q;
    assign out_data_o  = head_data_q;
    assign occ_o       = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            head_icode_q <= BUBBLE_ICODE;
            head_stat_q  <= BUBBLE_STAT;
            head_data_q  <= '0;
`ifdef PIPE_SKID_REG_SKID_EN
            skid_icode_q <= '0;
            skid_stat_q  <= '0;
            skid_data_q  <= '0;
`endif
        end else if (bubble_i) begin
            // Flush everything, including a beat offered this cycle, and leave a nop at the head.
            state_q      <= HALF;
            head_icode_q <= BUBBLE_ICODE;
            head_stat_q  <= BUBBLE_STAT;
            head_data_q  <= '0;
`ifdef PIPE_SKID_REG_SKID_EN
            skid_icode_q <= '0;
            skid_stat_q  <= '0;
            skid_data_q  <= '0;
`endif
        end else if (!stall_i) begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q      <= HALF;
                        head_icode_q <= in_icode_i;
                        head_stat_q  <= in_stat_i;
                        head_data_q  <= in_data_i;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        head_icode_q <= in_icode_i;
                        head_stat_q  <= in_stat_i;
                        head_data_q  <= in_data_i;
`ifdef PIPE_SKID_REG_SKID_EN
                    end else if (push) begin
                        state_q      <= FULL;
                        skid_icode_q <= in_icode_i;
                        skid_stat_q  <= in_stat_i;
                        skid_data_q  <= in_data_i;
`endif
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
`ifdef PIPE_SKID_REG_SKID_EN
                FULL: begin
                    if (pop) begin
                        state_q      <= HALF;
                        head_icode_q <= skid_icode_q;
                        head_stat_q  <= skid_stat_q;
                        head_data_q  <= skid_data_q;
                    end
                end
`endif
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised and directed bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;
    localparam int         DW   = 136;
    localparam logic [3:0] B_IC = 4'h1;
    localparam logic [2:0] B_ST = 3'd1;
`ifdef PIPE_SKID_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [3:0]    icode;
        logic [2:0]    stat;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, stall_i, bubble_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [3:0]    in_icode_i, out_icode_o;
    logic [2:0]    in_stat_i, out_stat_o;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [1:0]    occ_o;

    pipe_skid_reg #(.DATA_W(DW), .BUBBLE_ICODE(B_IC), .BUBBLE_STAT(B_ST)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .bubble_i(bubble_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_icode_i(in_icode_i),
        .in_stat_i(in_stat_i), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_icode_o(out_icode_o), .out_stat_o(out_stat_o),
        .out_data_o(out_data_o), .occ_o(occ_o)
    );

    always #5 clk = ~clk;

    beat_t mq[$];
    beat_t head_m;
    bit    model_ok = 1'b0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready();
        if (stall_i) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready_i;
    endfunction

    function automatic logic exp_valid();
        return !stall_i && (mq.size() != 0);
    endfunction

    task automatic cmp_all();
        chk("valid", DW'(out_valid_o), DW'(exp_valid()));
        chk("ready", DW'(in_ready_o), DW'(exp_ready()));
        chk("occ", DW'(occ_o), DW'(mq.size()));
        chk("icode", DW'(out_icode_o), DW'(head_m.icode));
        chk("stat", DW'(out_stat_o), DW'(head_m.stat));
        chk("data", out_data_o, head_m.data);
    endtask

    // One clock cycle: apply inputs, compare against the model, clock, advance the model.
    task automatic step(input logic r, input logic st, input logic bub, input logic iv,
                        input logic ordy, input logic [3:0] ic, input logic [2:0] is,
                        input logic [DW-1:0] d);
        logic  p, q;
        beat_t b;
        rst = r; stall_i = st; bubble_i = bub; in_valid_i = iv; out_ready_i = ordy;
        in_icode_i = ic; in_stat_i = is; in_data_i = d;
        #1;
        if (model_ok) cmp_all();
        p = iv && exp_ready();
        q = exp_valid() && ordy;
        b = '{icode: ic, stat: is, data: d};
        @(posedge clk);
        if (r) begin
            mq.delete();
            head_m   = '{icode: B_IC, stat: B_ST, data: '0};
            model_ok = 1'b1;
        end else if (bub) begin
            mq.delete();
            head_m = '{icode: B_IC, stat: B_ST, data: '0};
            mq.push_back(head_m);
        end else begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(b);
            if (mq.size() != 0) head_m = mq[0];
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 1'b0, ordy, 4'h0, 3'd0, '0);
    endtask

    task automatic push_beat(input logic [3:0] ic, input logic ordy);
        step(1'b0, 1'b0, 1'b0, 1'b1, ordy, ic, 3'd2, DW'({ic, 8'hA5}));
    endtask

    initial begin
        logic [DW-1:0]  d21;
        logic [159:0]   rnd;
        d21 = {4'd5, 4'd6, 64'h8, 64'h2};

        // Reset values
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, '0);
        chk("rst_occ", DW'(occ_o), DW'(2'd0));
        chk("rst_valid", DW'(out_valid_o), DW'(1'b0));
        chk("rst_icode", DW'(out_icode_o), DW'(4'h1));
        chk("rst_stat", DW'(out_stat_o), DW'(3'd1));
        chk("rst_data", out_data_o, '0);
        idle(1'b0);
        chk("rst_ready", DW'(in_ready_o), DW'(1'b1));

        // Single beat with one-cycle latency
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 3'd1, d21);
        chk("lat_valid", DW'(out_valid_o), DW'(1'b1));
        chk("lat_icode", DW'(out_icode_o), DW'(4'h6));
        chk("lat_stat", DW'(out_stat_o), DW'(3'd1));
        chk("lat_data", out_data_o, d21);
        chk("lat_occ", DW'(occ_o), DW'(2'd1));
        idle(1'b1);
        chk("drain_occ", DW'(occ_o), DW'(2'd0));

        // Back-pressure: fill then drain in order
        push_beat(4'h6, 1'b0);
        push_beat(4'h3, 1'b0);
`ifdef PIPE_SKID_REG_SKID_EN
        chk("full_occ", DW'(occ_o), DW'(2'd2));
        chk("full_ready", DW'(in_ready_o), DW'(1'b0));
        idle(1'b1);
        chk("order_icode2", DW'(out_icode_o), DW'(4'h3));
        idle(1'b1);
        chk("order_occ", DW'(occ_o), DW'(2'd0));
        push_beat(4'h6, 1'b0);
        push_beat(4'h3, 1'b0);
`else
        chk("single_occ", DW'(occ_o), DW'(2'd1));
        chk("single_icode", DW'(out_icode_o), DW'(4'h6));
`endif

        // Bubble from the fullest state
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 3'd2, '1);
        chk("bub_icode", DW'(out_icode_o), DW'(4'h1));
        chk("bub_stat", DW'(out_stat_o), DW'(3'd1));
        chk("bub_data", out_data_o, '0);
        chk("bub_occ", DW'(occ_o), DW'(2'd1));
        idle(1'b1);
        chk("bub_drain", DW'(occ_o), DW'(2'd0));

        // Stall freezes state for three cycles
        push_beat(4'h9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 3'd3, '1);
            chk("stall_valid", DW'(out_valid_o), DW'(1'b0));
            chk("stall_ready", DW'(in_ready_o), DW'(1'b0));
            chk("stall_occ", DW'(occ_o), DW'(2'd1));
            chk("stall_icode", DW'(out_icode_o), DW'(4'h9));
        end
        idle(1'b1);
        chk("stall_rel_occ", DW'(occ_o), DW'(2'd0));

        // Priority: bubble over stall, reset over bubble
        push_beat(4'h4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, '0);
        chk("bubstall_icode", DW'(out_icode_o), DW'(4'h1));
        chk("bubstall_occ", DW'(occ_o), DW'(2'd1));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, '0);
        chk("rstbub_occ", DW'(occ_o), DW'(2'd0));
        chk("rstbub_valid", DW'(out_valid_o), DW'(1'b0));

        // Streaming: one beat per cycle
        push_beat(4'h0, 1'b1);
        for (int i = 1; i < 6; i++) begin
            push_beat(4'(i), 1'b1);
            chk("stream_icode", DW'(out_icode_o), DW'(i));
`ifndef PIPE_SKID_REG_SKID_EN
            chk("stream_occ", DW'(occ_o), DW'(2'd1));
`endif
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1,
                 4'($urandom), 3'($urandom), rnd[DW-1:0]);
            chk("model_cap", DW'(mq.size() <= CAP), DW'(1'b1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-002 Parameters (name, default, meaning), SHALL be:
- DATA_W, 136, payload width (rA,rB,valC,valP packed by the instantiating stage).
- BUBBLE_ICODE, 4'h1, icode of an injected bubble (nop).
- BUBBLE_STAT, 3'd1, stat of an injected bubble (AOK).
REQ-003 Ports (name, direction, width, meaning), in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  freeze stage.
- bubble_i  in  1  flush and inject bubble.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage accepts beat.
- in_icode_i  in  4  upstream icode.
- in_stat_i  in  3  upstream stat.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts.
- out_icode_o  out  4  head icode.
- out_stat_o  out  3  head stat.
- out_data_o  out  DATA_W  head payload.
- occ_o  out  2  entries held (0..2).

Function
REQ-004 SHALL hold up to two entries (head, skid) in FIFO order; outputs SHALL always drive the head register.
REQ-005 SHALL have states EMPTY (occ 0), HALF (occ 1), FULL (occ 2); occ_o SHALL equal the state encoding.
REQ-006 out_valid_o SHALL be !stall_i && occ!=0.
REQ-007 push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i; both evaluated at the same clk edge.
REQ-008 Transitions: EMPTY+push -> HALF (head=input); HALF+push only -> FULL (skid=input); HALF+pop only -> EMPTY; HALF+push+pop -> HALF (head=input); FULL+pop -> HALF (head=skid); otherwise hold.
REQ-009 Latency: a beat pushed at edge N into EMPTY SHALL appear on outputs after edge N (one cycle).
REQ-010 stall_i high SHALL force in_ready_o=0 and out_valid_o=0 and SHALL hold all state and outputs unchanged.
REQ-011 bubble_i high at an edge SHALL discard head, skid and any input beat, and SHALL load head with {BUBBLE_ICODE, BUBBLE_STAT, DATA_W'0}, state HALF.
REQ-012 Priority SHALL be rst > bubble_i > stall_i > push/pop.
REQ-013 In EMPTY, head contents SHALL hold their last value (not meaningful, out_valid_o=0).
REQ-014 Payload SHALL pass unmodified, bit-exact, no width conversion.

Reset
REQ-015 rst high at an edge SHALL set state EMPTY, occ_o=0, out_valid_o=0, out_icode_o=BUBBLE_ICODE, out_stat_o=BUBBLE_STAT, out_data_o=0, skid cleared.
REQ-016 After reset with stall_i low, in_ready_o SHALL be 1.
REQ-017 rst mid-operation SHALL drop all held entries, including FULL; no beat is emitted on the reset edge.

Configuration
REQ-018 Macro PIPE_SKID_REG_SKID_EN SHALL select the buffering mode.
REQ-019 Defined: two-entry operation as above; in_ready_o = !stall_i && occ!=2 (no combinational path from out_ready_i).
REQ-020 Undefined: single entry only, FULL unreachable, occ_o<=1; in_ready_o = !stall_i && (occ==0 || out_ready_i); bubble, stall, reset behaviour unchanged.

Verification
REQ-021 Reset, then push icode 6, stat 1, data {5,6,64'h8,64'h2} with out_ready_i=1 -> out_valid_o=1 next cycle, fields identical, occ_o=1.
REQ-022 (SKID_EN) out_ready_i=0, push icode 6 then icode 3 -> occ_o=2, in_ready_o=0; raise out_ready_i -> icode 6 then icode 3 emitted in order.
REQ-023 occ_o=2, assert bubble_i one cycle -> next cycle out_icode_o=1, out_stat_o=1, out_data_o=0, occ_o=1; old entries never emitted.
REQ-024 occ_o=1, stall_i=1 for 3 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=0, occ_o and outputs unchanged; release -> original head emitted.
REQ-025 stall_i and bubble_i both high -> bubble loaded (bubble wins); rst with bubble_i high -> EMPTY, out_valid_o=0.
REQ-026 (no SKID_EN) occ_o=1, in_valid_i=1, out_ready_i=1 every cycle -> one beat per cycle throughput, occ_o stays 1.
